halt_reporter: RTL and testbench



---
 rtl/halt_reporter_if.sv | 22 ++
 rtl/halt_reporter.sv | 104 ++++++++++
 tb/tb_halt_reporter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/halt_reporter_if.sv
// Halt-report link: decoder strobe and accumulator in, UART TX start/done handshake out.
interface halt_reporter_if #(
  parameter int DATA_W = 16
);
  logic              wr_uart;
  logic [DATA_W-1:0] acc;
  logic              tx_done;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              busy;
  logic              report_done;

  modport master (
    output wr_uart, acc, tx_done,
    input  tx_start, tx_data, busy, report_done
  );

  modport slave (
    input  wr_uart, acc, tx_done,
    output tx_start, tx_data, busy, report_done
  );
endinterface

// File: rtl/halt_reporter.sv
// Snapshots {acc, cycle counter} on the first HLT cycle and streams it to the UART, MSB byte first.
// Define HALT_REPORTER_HDR_EN to prefix every report with the header byte 8'hA5.
module halt_reporter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  halt_reporter_if.slave   bus
);

`ifdef HALT_REPORTER_HDR_EN
  localparam int HDR_B = 1;
`else
  localparam int HDR_B = 0;
`endif
  localparam int NB    = HDR_B + DATA_W / 8 + CNT_W / 8;
  localparam int SR_W  = NB * 8;
  localparam int IDX_W = $clog2(NB + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              wr_uart_q, wr_uart_d;
  logic              halt_edge;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sr_d      = sr_q;
    wr_uart_d = bus.wr_uart;
    halt_edge = bus.wr_uart & ~wr_uart_q;

    case (state_q)
      IDLE: begin
        if (halt_edge) begin
`ifdef HALT_REPORTER_HDR_EN
          sr_d = {8'hA5, bus.acc, cnt_q};
`else
          sr_d = {bus.acc, cnt_q};
`endif
          state_d = SEND;
        end else if (!bus.wr_uart && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND: begin
        state_d = WAIT;
      end
      WAIT: begin
        // The top byte of sr_q is what the UART is sending; shift only once it has left the line.
        if (bus.tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            sr_d    = {sr_q[SR_W-9:0], 8'h00};
            state_d = SEND;
          end
        end
      end
      DONE: begin
        if (!bus.wr_uart) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sr_q      <= '0;
      wr_uart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      wr_uart_q <= wr_uart_d;
    end
  end

  assign bus.tx_start    = (state_q == SEND);
  assign bus.tx_data     = sr_q[SR_W-1 -: 8];
  assign bus.busy        = (state_q == SEND) || (state_q == WAIT);
  assign bus.report_done = (state_q == DONE);

endmodule

// File: tb/tb_halt_reporter.sv
// Scoreboard bench for halt_reporter: expected bytes queued by the stimulus, popped on every tx_start.
module tb_halt_reporter;

`ifdef HALT_REPORTER_HDR_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic clk;
  logic rst_n;
  logic model_done;
  logic force_done;

  int total;
  int bad;
  int n_starts;

  logic [7:0] sbq[$];
  logic [7:0] last_byte;
  int         tx_cd;

  halt_reporter_if #(.DATA_W(16)) bus ();

  assign bus.tx_done = model_done | force_done;

  halt_reporter #(
    .DATA_W(16),
    .CNT_W (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_report(input logic [15:0] a, input logic [31:0] c);
`ifdef HALT_REPORTER_HDR_EN
    sbq.push_back(8'hA5);
`endif
    sbq.push_back(a[15:8]);
    sbq.push_back(a[7:0]);
    sbq.push_back(c[31:24]);
    sbq.push_back(c[23:16]);
    sbq.push_back(c[15:8]);
    sbq.push_back(c[7:0]);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.report_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.report_done), 32'd1);
  endtask

  task automatic wait_start(input string name, input int k, input int budget);
    int seen;
    int n;
    seen = 0;
    n    = 0;
    while (seen < k && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.tx_start) seen++;
    end
    chk(name, 32'(seen), 32'(k));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_report_done"}, 32'(bus.report_done), 32'd0);
  endtask

  // UART TX model: tx_done three cycles after each tx_start.
  always @(negedge clk) begin
    model_done <= 1'b0;
    if (tx_cd > 0) begin
      tx_cd = tx_cd - 1;
      if (tx_cd == 0) model_done <= 1'b1;
    end
    if (bus.tx_start) tx_cd = 3;
  end

  // Monitor: every byte offered must be the next one queued, and must hold until tx_done.
  always @(negedge clk) begin
    if (rst_n && bus.tx_start) begin
      n_starts++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tx_start actual=%0h expected=none at %0t", bus.tx_data, $time);
      end else begin
        chk("tx_byte", 32'(bus.tx_data), 32'(sbq.pop_front()));
      end
      last_byte = bus.tx_data;
    end
    if (rst_n && bus.tx_done && bus.busy) chk("tx_data_hold", 32'(bus.tx_data), 32'(last_byte));
  end

  initial begin
    int base;
    total      = 0;
    bad        = 0;
    n_starts   = 0;
    tx_cd      = 0;
    last_byte  = 8'h00;
    model_done = 1'b0;
    force_done = 1'b0;
    rst_n      = 1'b0;
    bus.wr_uart = 1'b0;
    bus.acc     = 16'h0000;

    // Reset values, then 10 idle cycles and a halt with acc=1234.
    repeat (2) @(negedge clk);
    chk_reset_outs("rst0");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    push_report(16'h1234, 32'd10);
    bus.wr_uart = 1'b1;
    bus.acc     = 16'h1234;
    @(negedge clk);
    chk("s1_start_latency", 32'(bus.tx_start), 32'd1);
    chk("s1_busy_rise", 32'(bus.busy), 32'd1);
    bus.acc = 16'h7777;
    wait_done("s1_done", 100);
    chk("s1_busy_fall", 32'(bus.busy), 32'd0);
    chk("s1_starts", 32'(n_starts), 32'(NB));

    // Held strobe must not re-report; rearm and report again after 5 idle cycles.
    repeat (200) @(negedge clk);
    chk("s2_no_rereport", 32'(n_starts), 32'(NB));
    chk("s2_still_done", 32'(bus.report_done), 32'd1);
    bus.wr_uart = 1'b0;
    @(negedge clk);
    chk("s2_rearm", 32'(bus.report_done), 32'd0);
    repeat (5) @(negedge clk);
    push_report(16'hFFFF, 32'd5);
    bus.wr_uart = 1'b1;
    bus.acc     = 16'hFFFF;
    wait_done("s2_done", 100);
    chk("s2_starts", 32'(n_starts), 32'(2 * NB));

    // acc change and strobe drop mid-report do not disturb the snapshot.
    bus.wr_uart = 1'b0;
    repeat (3) @(negedge clk);
    push_report(16'hABCD, 32'd2);
    bus.wr_uart = 1'b1;
    bus.acc     = 16'hABCD;
    wait_start("s3_byte1_start", 2, 50);
    @(negedge clk);
    bus.acc     = 16'h0000;
    bus.wr_uart = 1'b0;
    wait_done("s3_done", 100);
    @(negedge clk);
    chk("s3_done_exit", 32'(bus.report_done), 32'd0);
    chk("s3_idle_busy", 32'(bus.busy), 32'd0);
    chk("s3_starts", 32'(n_starts), 32'(3 * NB));

    // tx_done pulses in IDLE and SEND are ignored.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    chk("s4_idle_done_ignored", 32'(bus.busy), 32'd0);
    push_report(16'h5A5A, 32'd3);
    bus.wr_uart = 1'b1;
    bus.acc     = 16'h5A5A;
    @(negedge clk);
    chk("s4_in_send", 32'(bus.tx_start), 32'd1);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    chk("s4_send_done_ignored", 32'(bus.busy), 32'd1);
    wait_done("s4_done", 100);
    chk("s4_starts", 32'(n_starts), 32'(4 * NB));

    // Reset during byte 3 abandons the report; counter restarts from 0.
    bus.wr_uart = 1'b0;
    @(negedge clk);
    push_report(16'h0F0F, 32'd0);
    bus.wr_uart = 1'b1;
    bus.acc     = 16'h0F0F;
    wait_start("s5_byte3_start", 4, 50);
    @(negedge clk);
    rst_n       = 1'b0;
    bus.wr_uart = 1'b0;
    @(negedge clk);
    chk_reset_outs("s5_rst");
    sbq.delete();
    base  = n_starts;
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    chk("s5_no_resume", 32'(n_starts), 32'(base));
    push_report(16'hC3C3, 32'd7);
    bus.wr_uart = 1'b1;
    bus.acc     = 16'hC3C3;
    wait_done("s5_done", 100);
    chk("s5_starts", 32'(n_starts - base), 32'(NB));
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
